// File: rtl/fan_tach_if.sv
// fan_tach_if
//   Bundles the tachometer pins and the per-window results of
//   fan_tach_monitor.
//   master : the monitor. It reads fan_tach and drives the results.
//   slave  : the board/sysinfo side. It drives fan_tach and reads the results.
// Signals
//   fan_tach    [NUM_FANS]     raw open-collector tach pins, asynchronous
//   fan_rpm     [16*NUM_FANS]  packed RPM, fan i at [16i+15:16i]
//   fan_stalled [NUM_FANS]     per-fan stall flag
//   rpm_valid                  high once the first window has completed
//   rpm_update                 one-cycle strobe when results refresh
interface fan_tach_if #(
  parameter int NUM_FANS = 2
);
  logic [NUM_FANS-1:0]    fan_tach;
  logic [16*NUM_FANS-1:0] fan_rpm;
  logic [NUM_FANS-1:0]    fan_stalled;
  logic                   rpm_valid;
  logic                   rpm_update;

  modport master (
    input  fan_tach,
    output fan_rpm,
    output fan_stalled,
    output rpm_valid,
    output rpm_update
  );

  modport slave (
    output fan_tach,
    input  fan_rpm,
    input  fan_stalled,
    input  rpm_valid,
    input  rpm_update
  );
endinterface

// File: rtl/fan_tach_monitor.sv
// fan_tach_monitor
//   Measures fan speed from tachometer pins. For each fan, the pin is
//   synchronised and glitch-filtered. Falling edges are counted over a fixed
//   gate window, and the count is scaled to RPM. Results are latched once
//   per window and announced with a single-cycle rpm_update strobe.
// Ports
//   clk       sysinfo clock
//   rst_n     asynchronous active-low reset
//   tach_bus  fan_tach_if master: fan_tach in; fan_rpm, fan_stalled,
//             rpm_valid, rpm_update out
module fan_tach_monitor #(
  parameter int NUM_FANS      = 2,
  parameter int WINDOW_CYCLES = 50000000,
  parameter int FILTER_CYCLES = 16,
  parameter int RPM_SCALE     = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  fan_tach_if.master  tach_bus
);

  localparam int WIN_W  = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam int FILT_W = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILTER_CYCLES - 1);
  localparam logic [31:0]       SCALE_32  = 32'(RPM_SCALE);

  logic [WIN_W-1:0] win_cnt_q;
  logic             win_end;
  logic             rpm_valid_q;
  logic             rpm_update_q;

  assign win_end = (win_cnt_q == WIN_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt_q    <= '0;
      rpm_valid_q  <= 1'b0;
      rpm_update_q <= 1'b0;
    end else begin
      win_cnt_q    <= win_end ? '0 : win_cnt_q + WIN_W'(1);
      rpm_update_q <= win_end;
      rpm_valid_q  <= rpm_valid_q | win_end;
    end
  end

  assign tach_bus.rpm_valid  = rpm_valid_q;
  assign tach_bus.rpm_update = rpm_update_q;

  for (genvar i = 0; i < NUM_FANS; i++) begin : g_fan
    (* ASYNC_REG = "TRUE" *) logic sync_q1;
    (* ASYNC_REG = "TRUE" *) logic sync_q2;
    logic              filt_q;
    logic              filt_d_q;
    logic [FILT_W-1:0] filt_cnt_q;
    logic              edge_pulse;
    logic [15:0]       edge_cnt_q;
    logic [15:0]       captured;
    logic [31:0]       product;
    logic [15:0]       rpm_q;
    logic              stalled_q;

    // Synchroniser and filter idle high, which matches an undriven
    // open-collector pin. This means no edge can appear out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_q1 <= 1'b1;
        sync_q2 <= 1'b1;
      end else begin
        sync_q1 <= tach_bus.fan_tach[i];
        sync_q2 <= sync_q1;
      end
    end

    // The filtered level follows only after FILTER_CYCLES consecutive
    // cycles of disagreement. A shorter pulse resets the run.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        filt_q     <= 1'b1;
        filt_d_q   <= 1'b1;
        filt_cnt_q <= '0;
      end else begin
        filt_d_q <= filt_q;
        if (sync_q2 == filt_q) begin
          filt_cnt_q <= '0;
        end else if (filt_cnt_q == FILT_LAST) begin
          filt_q     <= sync_q2;
          filt_cnt_q <= '0;
        end else begin
          filt_cnt_q <= filt_cnt_q + FILT_W'(1);
        end
      end
    end

    assign edge_pulse = filt_d_q & ~filt_q;

    // Saturating count that includes this cycle's edge. On the window-end
    // cycle this is the closing window's total, so an edge landing there
    // is never carried into the next window.
    assign captured = (edge_pulse && (edge_cnt_q != 16'hFFFF)) ?
                      edge_cnt_q + 16'd1 : edge_cnt_q;
    assign product  = {16'd0, captured} * SCALE_32;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        edge_cnt_q <= '0;
        rpm_q      <= '0;
        stalled_q  <= 1'b0;
      end else if (win_end) begin
        edge_cnt_q <= '0;
        rpm_q      <= (product > 32'h0000_FFFF) ? 16'hFFFF : product[15:0];
        stalled_q  <= (captured == 16'd0);
      end else begin
        edge_cnt_q <= captured;
      end
    end

    assign tach_bus.fan_rpm[16*i +: 16] = rpm_q;
    assign tach_bus.fan_stalled[i]      = stalled_q;
  end

endmodule

// File: tb/tb_fan_tach_monitor.sv
// Bench for fan_tach_monitor.
// dut_a uses FILTER_CYCLES=4 and RPM_SCALE=30.
// dut_b uses FILTER_CYCLES=1 and RPM_SCALE=30.
// dut_c uses FILTER_CYCLES=1 and RPM_SCALE=1000.
// All three use WINDOW_CYCLES=1000.
// Pins change on the falling clock edge. Results are sampled 2 ns after the
// rising edge.
module tb_fan_tach_monitor;
  localparam int W = 1000;

  localparam int M_HIGH  = 0;
  localparam int M_LOW   = 1;
  localparam int M_SQ100 = 2;
  localparam int M_SQ200 = 3;
  localparam int M_GL3   = 4;
  localparam int M_GL6   = 5;
  localparam int M_BOUND = 6;
  localparam int M_SQ10  = 7;

  typedef struct packed {
    logic [15:0] r0;
    logic [15:0] r1;
    logic [1:0]  st;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fan_tach_if #(.NUM_FANS(2)) bus_a ();
  fan_tach_if #(.NUM_FANS(2)) bus_b ();
  fan_tach_if #(.NUM_FANS(2)) bus_c ();

  fan_tach_monitor #(.NUM_FANS(2), .WINDOW_CYCLES(W), .FILTER_CYCLES(4), .RPM_SCALE(30))
    dut_a (.clk(clk), .rst_n(rst_n), .tach_bus(bus_a));
  fan_tach_monitor #(.NUM_FANS(2), .WINDOW_CYCLES(W), .FILTER_CYCLES(1), .RPM_SCALE(30))
    dut_b (.clk(clk), .rst_n(rst_n), .tach_bus(bus_b));
  fan_tach_monitor #(.NUM_FANS(2), .WINDOW_CYCLES(W), .FILTER_CYCLES(1), .RPM_SCALE(1000))
    dut_c (.clk(clk), .rst_n(rst_n), .tach_bus(bus_c));

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   g = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Pin level for a mode at window phase p (falling edges hand-placed)
  function automatic logic pin(input int mode, input int p);
    case (mode)
      M_HIGH:  return 1'b1;
      M_LOW:   return 1'b0;
      M_SQ100: return (p % 100) < 50;                          // 10 falls/window
      M_SQ200: return (p % 200) < 100;                         // 5 falls/window
      M_GL3:   return !(((p % 50) >= 20) && ((p % 50) < 23));  // 3-cycle lows
      M_GL6:   return !(((p % 50) >= 20) && ((p % 50) < 26));  // 6-cycle lows
      M_BOUND: return ((p % 100) >= 43) && ((p % 100) < 93);   // falls at 93+100k
      M_SQ10:  return (p % 10) < 5;                            // 100 falls/window
      default: return 1'b1;
    endcase
  endfunction

  task automatic drive_cycles(input int m0, input int m1, input int ncyc);
    for (int k = 0; k < ncyc; k++) begin
      int p;
      p = g % W;
      bus_a.fan_tach = {pin(m1, p), pin(m0, p)};
      bus_b.fan_tach = {1'b1, pin(M_SQ10, p)};
      bus_c.fan_tach = {1'b1, pin(M_SQ10, p)};
      @(negedge clk);
      g++;
    end
  endtask

  task automatic window(input int m0, input int m1, input logic [15:0] r0,
                        input logic [15:0] r1, input logic [1:0] st);
    q_a.push_back('{r0: r0, r1: r1, st: st});
    q_b.push_back('{r0: 16'd3000, r1: 16'd0, st: 2'b10});
    q_c.push_back('{r0: 16'hFFFF, r1: 16'd0, st: 2'b10});
    drive_cycles(m0, m1, W);
  endtask

  // Scoreboard monitor
  int   pc = 0;
  bit   seen = 1'b0;
  always @(posedge clk) begin
    exp_t e;
    #2;
    if (!rst_n) begin
      pc   = 0;
      seen = 1'b0;
    end else begin
      pc++;
      if (bus_a.rpm_update) begin
        check("a_update_spacing", pc, W);
        pc   = 0;
        seen = 1'b1;
        if (q_a.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL a_unexpected_update: got update, required none (t=%0t)", $time);
        end else begin
          e = q_a.pop_front();
          check("a_rpm0", bus_a.fan_rpm[15:0], e.r0);
          check("a_rpm1", bus_a.fan_rpm[31:16], e.r1);
          check("a_stalled", bus_a.fan_stalled, e.st);
          check("a_valid_at_update", bus_a.rpm_valid, 1);
        end
      end else begin
        check("a_valid_level", bus_a.rpm_valid, seen);
      end
      if (bus_b.rpm_update) begin
        if (q_b.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL b_unexpected_update: got update, required none (t=%0t)", $time);
        end else begin
          e = q_b.pop_front();
          check("b_rpm0", bus_b.fan_rpm[15:0], e.r0);
          check("b_rpm1", bus_b.fan_rpm[31:16], e.r1);
          check("b_stalled", bus_b.fan_stalled, e.st);
        end
      end
      if (bus_c.rpm_update) begin
        if (q_c.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL c_unexpected_update: got update, required none (t=%0t)", $time);
        end else begin
          e = q_c.pop_front();
          check("c_rpm0", bus_c.fan_rpm[15:0], e.r0);
          check("c_rpm1", bus_c.fan_rpm[31:16], e.r1);
          check("c_stalled", bus_c.fan_stalled, e.st);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_a.fan_tach = 2'b11;
    bus_b.fan_tach = 2'b11;
    bus_c.fan_tach = 2'b11;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_rpm", bus_a.fan_rpm, 0);
    check("rst_stalled", bus_a.fan_stalled, 0);
    check("rst_valid", bus_a.rpm_valid, 0);
    check("rst_update", bus_a.rpm_update, 0);
    @(negedge clk);
    rst_n = 1'b1;
    g = 0;

    window(M_SQ100, M_HIGH,  16'd300, 16'd0,   2'b10);
    window(M_SQ100, M_HIGH,  16'd300, 16'd0,   2'b10);
    window(M_SQ100, M_SQ200, 16'd300, 16'd150, 2'b00);
    window(M_GL3,   M_HIGH,  16'd0,   16'd0,   2'b11);
    window(M_GL6,   M_HIGH,  16'd600, 16'd0,   2'b10);
    window(M_LOW,   M_HIGH,  16'd30,  16'd0,   2'b10);  // the single fall at entry
    window(M_LOW,   M_HIGH,  16'd0,   16'd0,   2'b11);
    window(M_SQ100, M_HIGH,  16'd300, 16'd0,   2'b10);
    window(M_BOUND, M_HIGH,  16'd300, 16'd0,   2'b10);  // 9 + one on window end
    window(M_BOUND, M_HIGH,  16'd300, 16'd0,   2'b10);  // must not be 11
    window(M_SQ100, M_HIGH,  16'd300, 16'd0,   2'b10);

    // 7 edges counted by phase 700, then reset
    drive_cycles(M_SQ100, M_HIGH, 700);
    rst_n = 1'b0;
    #1;
    check("midrst_rpm", bus_a.fan_rpm, 0);
    check("midrst_stalled", bus_a.fan_stalled, 0);
    check("midrst_valid", bus_a.rpm_valid, 0);
    check("midrst_update", bus_a.rpm_update, 0);
    check("midrst_rpm_c", bus_c.fan_rpm, 0);
    bus_a.fan_tach = 2'b11;
    bus_b.fan_tach = 2'b11;
    bus_c.fan_tach = 2'b11;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    g = 0;

    window(M_SQ100, M_HIGH,  16'd300, 16'd0,   2'b10);
    window(M_HIGH,  M_SQ200, 16'd0,   16'd150, 2'b01);

    drive_cycles(M_HIGH, M_HIGH, 20);
    check("a_queue_drained", q_a.size(), 0);
    check("b_queue_drained", q_b.size(), 0);
    check("c_queue_drained", q_c.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
